// File: rtl/vga_pkg.sv
// Shared VGA definitions: fetch FSM states, pixel modes, bytes-per-pixel lookup
// and the register bitfield widths.
package vga_pkg;

  localparam int unsigned TIMING_W  = 16;
  localparam int unsigned VISIBLE_W = 16;
  localparam int unsigned BRULEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    AR   = 2'b01,
    R    = 2'b10
  } fetch_state_t;

  typedef enum logic [1:0] {
    RGB332 = 2'd0,
    RGB444 = 2'd1,
    RGB555 = 2'd2,
    RGB565 = 2'd3
  } pix_mode_t;

  function automatic logic [1:0] bpp(input pix_mode_t mode);
    return (mode == RGB332) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/vga_fb_fetch_ctrl.sv
// Framebuffer read scheduler: one AXI read burst at a time, double-buffered base.
// Optional VGA_FETCH_UNDERRUN_EN adds the underrun pulse and a debug counter.
module vga_fb_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_AW    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic [BRULEN_W-1:0]   brulen_i,
  input  logic [VISIBLE_W-1:0]  hvlen_i,
  input  logic [VISIBLE_W-1:0]  vvlen_i,
  input  logic [31:0]           fbba1_i,
  input  logic [31:0]           fbba2_i,
  input  logic                  vbse_i,
  input  logic                  frame_start_i,
  input  logic [FIFO_AW:0]      fifo_free_i,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [ADDR_WIDTH-1:0] ar_addr_o,
  output logic [7:0]            ar_len_o,
  input  logic                  r_valid_i,
  input  logic                  r_last_i,
  output logic                  cfb_o,
  output logic                  vbsif_set_o,
  output logic                  busy_o,
  output logic                  underrun_o
);

  localparam int unsigned CNT_W = 32;

  fetch_state_t          state;
  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      frame_words;
  logic [ADDR_WIDTH-1:0] base;
  logic                  pending;

  logic [CNT_W-1:0]      req_len;
  logic [CNT_W-1:0]      cap_len;
  logic [CNT_W-1:0]      remaining;
  logic [CNT_W-1:0]      blen;
  logic [CNT_W-1:0]      new_words;
  logic                  restart;
  logic                  new_cfb;

  // Burst sizing, frame size and restart decode
  always_comb begin
    req_len   = CNT_W'(brulen_i) + CNT_W'(1);
    cap_len   = CNT_W'(1) << FIFO_AW;
    remaining = frame_words - word_cnt;
    blen      = req_len;
    if (cap_len < blen)   blen = cap_len;
    if (remaining < blen) blen = remaining;
    new_words = (CNT_W'(hvlen_i) * CNT_W'(vvlen_i) * CNT_W'(bpp(pix_mode_t'(mode_i)))
                 + CNT_W'(3)) >> 2;
    restart   = (state == IDLE) && en_i && (frame_start_i || pending);
    new_cfb   = cfb_o ^ vbse_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      word_cnt    <= '0;
      frame_words <= '0;
      base        <= '0;
      pending     <= 1'b0;
      ar_valid_o  <= 1'b0;
      ar_addr_o   <= '0;
      ar_len_o    <= '0;
      cfb_o       <= 1'b0;
      vbsif_set_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      vbsif_set_o <= 1'b0;
      // A frame start during an open transaction is deferred until it drains
      if (frame_start_i && busy_o && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (restart) begin
            pending     <= 1'b0;
            if (vbse_i) begin
              cfb_o       <= new_cfb;
              vbsif_set_o <= 1'b1;
            end
            base        <= ADDR_WIDTH'(new_cfb ? fbba2_i : fbba1_i);
            frame_words <= new_words;
            word_cnt    <= '0;
            busy_o      <= (new_words != '0);
          end else begin
            if (!en_i) pending <= 1'b0;
            if (busy_o && en_i && word_cnt < frame_words && CNT_W'(fifo_free_i) >= blen) begin
              state      <= AR;
              ar_valid_o <= 1'b1;
              ar_addr_o  <= base + ADDR_WIDTH'(word_cnt << 2);
              ar_len_o   <= 8'(blen - CNT_W'(1));
            end else if (busy_o && (!en_i || word_cnt >= frame_words)) begin
              busy_o <= 1'b0;
            end
          end
        end
        AR: begin
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            state      <= R;
            word_cnt   <= word_cnt + CNT_W'(ar_len_o) + CNT_W'(1);
          end
        end
        R: begin
          if (r_valid_i && r_last_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_FETCH_UNDERRUN_EN
  logic        underrun_q;
  logic [15:0] underrun_cnt;

  // Underrun pulse plus saturating debug count
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      underrun_q   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun_q <= frame_start_i && busy_o;
      if (frame_start_i && busy_o && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  assign underrun_o = underrun_q;
`else
  assign underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_fetch_ctrl.sv
// Bench for vga_fb_fetch_ctrl: directed cases plus random frames checked against
// a burst-list model. Underrun checks follow VGA_FETCH_UNDERRUN_EN.
module tb_vga_fb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  brulen;
  logic [15:0] hvlen, vvlen;
  logic [31:0] fbba1, fbba2;
  logic        vbse;
  logic        frame_start;
  logic [8:0]  fifo_free;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid, r_last;
  logic        cfb, vbsif_set, busy, underrun;

  int passed = 0;
  int total  = 0;

  int unsigned q_addr[$];
  int unsigned q_len[$];
  logic        exp_cfb = 1'b0;
  int unsigned exp_fw;

  always #5 clk = ~clk;

  vga_fb_fetch_ctrl #(.ADDR_WIDTH(32), .FIFO_AW(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .mode_i(mode), .brulen_i(brulen),
    .hvlen_i(hvlen), .vvlen_i(vvlen), .fbba1_i(fbba1), .fbba2_i(fbba2),
    .vbse_i(vbse), .frame_start_i(frame_start), .fifo_free_i(fifo_free),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
    .ar_len_o(ar_len), .r_valid_i(r_valid), .r_last_i(r_last), .cfb_o(cfb),
    .vbsif_set_o(vbsif_set), .busy_o(busy), .underrun_o(underrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Expected burst list: linear walk of the frame in chunks of min(brulen+1, 256, remaining)
  task automatic build_q(input int unsigned base);
    int unsigned bytes, wc, b;
    bytes  = int'(hvlen) * int'(vvlen) * ((mode == 2'd0) ? 1 : 2);
    exp_fw = (bytes + 3) / 4;
    q_addr.delete();
    q_len.delete();
    wc = 0;
    while (wc < exp_fw) begin
      b = int'(brulen) + 1;
      if (b > 256) b = 256;
      if (b > exp_fw - wc) b = exp_fw - wc;
      q_addr.push_back(base + wc * 4);
      q_len.push_back(b - 1);
      wc += b;
    end
  endtask

  task automatic start_frame(input int unsigned h, input int unsigned v, input logic [1:0] m,
                             input logic [7:0] bl, input logic vb);
    hvlen = 16'(h); vvlen = 16'(v); mode = m; brulen = bl; vbse = vb;
    fbba1 = $urandom & 32'hFFFF_FFFC;
    fbba2 = $urandom & 32'hFFFF_FFFC;
    if (vb) exp_cfb = ~exp_cfb;
    build_q(exp_cfb ? fbba2 : fbba1);
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    chk("cfb_after_start", cfb, exp_cfb);
    chk("vbsif_pulse", vbsif_set, vb);
    chk("busy_after_start", busy, exp_fw != 0);
    // Base must already be latched; later register writes must not matter
    fbba1 = $urandom & 32'hFFFF_FFFC;
    fbba2 = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic run_bursts(input int unsigned rdy_pct);
    int   phase = 0;
    int   beats = 0;
    int   cyc   = 0;
    logic done  = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      r_valid = 1'b0; r_last = 1'b0;
      chk("vbsif_idle", vbsif_set, 1'b0);
      if (phase == 0) begin
        if (ar_valid) begin
          if (q_addr.size() == 0) begin
            chk("extra_ar", ar_valid, 1'b0);
            ar_ready = 1'b1;
          end else begin
            chk("ar_addr", ar_addr, q_addr[0]);
            chk("ar_len", ar_len, q_len[0]);
            ar_ready = ($urandom_range(99) < rdy_pct);
            if (ar_ready) begin
              beats = q_len[0] + 1;
              phase = 1;
              void'(q_addr.pop_front());
              void'(q_len.pop_front());
            end
          end
        end else begin
          ar_ready = 1'($urandom_range(1));
          if (q_addr.size() == 0 && !busy) done = 1'b1;
        end
      end else begin
        ar_ready = 1'b0;
        chk("no_ar_in_r", ar_valid, 1'b0);
        if ($urandom_range(3) != 0) begin
          r_valid = 1'b1;
          beats--;
          r_last = (beats == 0);
          if (beats == 0) phase = 0;
        end
      end
    end
    chk("frame_done_in_budget", done, 1'b1);
    chk("all_bursts_issued", q_addr.size(), 0);
    chk("busy_low_at_end", busy, 1'b0);
    r_valid = 1'b0; r_last = 1'b0; ar_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 2'd3; brulen = 8'd3; hvlen = '0; vvlen = '0;
    fbba1 = 32'h1000_0000; fbba2 = 32'h2000_0000; vbse = 1'b0; frame_start = 1'b0;
    fifo_free = 9'd64; ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ar_valid", ar_valid, 1'b0);
    chk("rst_addr", ar_addr, 32'h0);
    chk("rst_len", ar_len, 8'h0);
    chk("rst_cfb", cfb, 1'b0);
    chk("rst_vbsif", vbsif_set, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    rst_n = 1'b1;

    // 8x2 RGB565, brulen 3: two bursts of 4 words, ready always high
    start_frame(8, 2, 2'd3, 8'd3, 1'b0);
    chk("t1_burst_count", q_addr.size(), 2);
    run_bursts(100);

    // 5x1 RGB332: 5 bytes -> 2 words, single burst len 1
    start_frame(5, 1, 2'd0, 8'd7, 1'b0);
    chk("t2_single_len", q_len[0], 1);
    run_bursts(100);

    // Insufficient FIFO room holds off the request, then AR stalls with ready low
    fifo_free = 9'd2; ar_ready = 1'b0;
    start_frame(8, 2, 2'd3, 8'd3, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("t3_no_ar_low_fifo", ar_valid, 1'b0);
    end
    fifo_free = 9'd4;
    @(negedge clk);
    chk("t3_ar_after_room", ar_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall_valid", ar_valid, 1'b1);
      chk("t4_stall_addr", ar_addr, q_addr[0]);
      chk("t4_stall_len", ar_len, q_len[0]);
    end
    fifo_free = 9'd64;
    run_bursts(100);

    // Buffer swap over two frames
    start_frame(8, 2, 2'd1, 8'd1, 1'b1);
    chk("t5_cfb_first", cfb, 1'b1);
    run_bursts(70);
    start_frame(6, 3, 2'd2, 8'd2, 1'b1);
    chk("t5_cfb_second", cfb, 1'b0);
    run_bursts(70);

    // Empty frame: no requests, busy stays low
    start_frame(0, 7, 2'd3, 8'd3, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("empty_no_ar", ar_valid, 1'b0);
      chk("empty_busy", busy, 1'b0);
    end

    // Disabled: frame start ignored, cfb held
    en = 1'b0;
    hvlen = 16'd8; vvlen = 16'd2; vbse = 1'b1;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    chk("dis_cfb_hold", cfb, exp_cfb);
    chk("dis_no_vbsif", vbsif_set, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("dis_no_ar", ar_valid, 1'b0);
      chk("dis_busy", busy, 1'b0);
    end
    en = 1'b1;

    // Frame restart while a burst is in flight
    begin
      int   cyc  = 0;
      logic seen = 1'b0;
      start_frame(32, 4, 2'd3, 8'd3, 1'b0);
      ar_ready = 1'b1;
      while (!seen && cyc < 50) begin
        @(negedge clk);
        cyc++;
        seen = ar_valid;
      end
      chk("ur_ar_seen", seen, 1'b1);
      chk("ur_first_addr", ar_addr, q_addr[0]);
      @(negedge clk);
      ar_ready = 1'b0; frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
`ifdef VGA_FETCH_UNDERRUN_EN
      chk("ur_pulse", underrun, 1'b1);
`else
      chk("ur_tied_low", underrun, 1'b0);
`endif
      chk("ur_busy_held", busy, 1'b1);
      for (int i = 0; i < 4; i++) begin
        r_valid = 1'b1; r_last = (i == 3);
        @(negedge clk);
        chk("ur_single_pulse", underrun, 1'b0);
        chk("ur_no_ar_drain", ar_valid, 1'b0);
      end
      r_valid = 1'b0; r_last = 1'b0;
      build_q(exp_cfb ? fbba2 : fbba1);
      run_bursts(80);
    end

    // Random frames against the burst model
    fifo_free = 9'd256;
    for (int f = 0; f < 8; f++) begin
      start_frame($urandom_range(40), $urandom_range(6), 2'($urandom_range(3)),
                  ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(15)),
                  1'($urandom_range(1)));
      run_bursts(60);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
